// File: rtl/usb_pkg.sv
// Shared PID encodings and sequencer state for the bulk-endpoint protocol controller.
package usb_pkg;

  typedef enum logic [2:0] {
    RX_NONE = 3'd0,
    RX_OUT  = 3'd1,
    RX_IN   = 3'd2,
    RX_DATA = 3'd3,
    RX_ACK  = 3'd4,
    RX_NAK  = 3'd5
  } rx_pid_t;

  typedef enum logic [1:0] {
    TX_NONE = 2'd0,
    TX_DATA = 2'd1,
    TX_ACK  = 2'd2,
    TX_NAK  = 2'd3
  } tx_pid_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_SEND_HS   = 3'd2,
    ST_SEND_DATA = 3'd3,
    ST_WAIT_ACK  = 3'd4
  } state_t;

endpackage

// File: rtl/usb_hs_timer.sv
// Bus-turnaround timer: saturating up-counter, flags when it has sat HS_TIMEOUT-1 cycles.
module usb_hs_timer #(
  parameter int HS_TIMEOUT = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int W = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
  localparam logic [W-1:0] TERM = W'(HS_TIMEOUT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over counting; counting stops at the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TERM)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign timeout = enable && (count_q == TERM);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// Bulk-endpoint transaction sequencer: token/handshake decode, TX commands, bus direction.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_IDLE      | waiting for an OUT or IN token
// ST_WAIT_DATA | OUT received, waiting for host DATA (buffer writes if accepted)
// ST_SEND_HS   | TX sending ACK/NAK handshake, TX owns the bus
// ST_SEND_DATA | TX sending IN payload, TX owns the bus
// ST_WAIT_ACK  | payload sent, waiting for host ACK
module usb_protocol_ctrl
  import usb_pkg::*;
#(
  parameter int HS_TIMEOUT = 64,
  parameter int MAX_PKT    = 64
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  rx_pid_t                        rx_packet,
  input  logic                           rx_done,
  input  logic                           rx_error,
  input  logic                           tx_done,
  input  logic                           tx_error,
  input  logic [$clog2(MAX_PKT+1)-1:0]   buffer_occupancy,
  input  logic                           tx_data_ready,
  output tx_pid_t                        tx_packet,
  output logic                           tx_start,
  output logic                           d_mode,
  output logic                           rx_store_en,
  output logic                           clear_buffer,
  output logic                           rx_data_ready,
  output logic                           tx_complete,
  output logic                           xfer_error
);

  state_t  state_q, state_d;
  tx_pid_t tx_packet_q, tx_packet_d;
  logic    accept_q, accept_d;
  logic    tx_start_q, tx_start_d;
  logic    d_mode_q, d_mode_d;
  logic    store_q, store_d;
  logic    clear_q, clear_d;
  logic    rdr_q, rdr_d;
  logic    txc_q, txc_d;
  logic    xerr_q, xerr_d;
  logic    timeout;

  usb_hs_timer #(.HS_TIMEOUT(HS_TIMEOUT)) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (state_d != state_q),
    .enable  ((state_q == ST_WAIT_DATA) || (state_q == ST_WAIT_ACK)),
    .timeout (timeout)
  );

  // Next state and next registered outputs; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    accept_d    = accept_q;
    tx_packet_d = TX_NONE;
    tx_start_d  = 1'b0;
    d_mode_d    = 1'b0;
    store_d     = 1'b0;
    clear_d     = 1'b0;
    rdr_d       = 1'b0;
    txc_d       = 1'b0;
    xerr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_done && !rx_error) begin
          if (rx_packet == RX_OUT) begin
            state_d  = ST_WAIT_DATA;
            accept_d = (buffer_occupancy == '0);
            store_d  = (buffer_occupancy == '0);
          end else if (rx_packet == RX_IN) begin
            state_d     = tx_data_ready ? ST_SEND_DATA : ST_SEND_HS;
            tx_packet_d = tx_data_ready ? TX_DATA : TX_NAK;
            tx_start_d  = 1'b1;
            d_mode_d    = 1'b1;
          end
        end
      end
      ST_WAIT_DATA: begin
        store_d = accept_q;
        // rx_done is checked before the timeout so a last-cycle DATA still counts.
        if (rx_done) begin
          if (!rx_error && (rx_packet == RX_DATA)) begin
            state_d     = ST_SEND_HS;
            tx_packet_d = accept_q ? TX_ACK : TX_NAK;
            tx_start_d  = 1'b1;
            d_mode_d    = 1'b1;
            rdr_d       = accept_q;
            store_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            xerr_d  = 1'b1;
            clear_d = accept_q;
            store_d = 1'b0;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          xerr_d  = 1'b1;
          clear_d = accept_q;
          store_d = 1'b0;
        end
      end
      ST_SEND_HS, ST_SEND_DATA: begin
        tx_packet_d = tx_packet_q;
        d_mode_d    = 1'b1;
        if (tx_error) begin
          state_d     = ST_IDLE;
          xerr_d      = 1'b1;
          tx_packet_d = TX_NONE;
          d_mode_d    = 1'b0;
        end else if (tx_done) begin
          state_d     = (state_q == ST_SEND_DATA) ? ST_WAIT_ACK : ST_IDLE;
          tx_packet_d = TX_NONE;
          d_mode_d    = 1'b0;
        end
      end
      ST_WAIT_ACK: begin
        // Buffer is kept on failure so the host can retry the IN.
        if (rx_done) begin
          state_d = ST_IDLE;
          if (!rx_error && (rx_packet == RX_ACK)) begin
            txc_d   = 1'b1;
            clear_d = 1'b1;
          end else begin
            xerr_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          xerr_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      accept_q    <= 1'b0;
      tx_packet_q <= TX_NONE;
      tx_start_q  <= 1'b0;
      d_mode_q    <= 1'b0;
      store_q     <= 1'b0;
      clear_q     <= 1'b0;
      rdr_q       <= 1'b0;
      txc_q       <= 1'b0;
      xerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      accept_q    <= accept_d;
      tx_packet_q <= tx_packet_d;
      tx_start_q  <= tx_start_d;
      d_mode_q    <= d_mode_d;
      store_q     <= store_d;
      clear_q     <= clear_d;
      rdr_q       <= rdr_d;
      txc_q       <= txc_d;
      xerr_q      <= xerr_d;
    end
  end

  assign tx_packet     = tx_packet_q;
  assign tx_start      = tx_start_q;
  assign d_mode        = d_mode_q;
  assign rx_store_en   = store_q;
  assign clear_buffer  = clear_q;
  assign rx_data_ready = rdr_q;
  assign tx_complete   = txc_q;
  assign xfer_error    = xerr_q;

endmodule
